match_judge: RTL

- Game-logic stage directly downstream of the card array.
- Watches every card's sel line, detects when two cards are selected, and compares their pattern types after a short display hold.
- Then pulses ms (match) or mf (mismatch) back to exactly the cards involved. Each card consumes those pulses to hide itself or return to normal.
- Also tracks remaining pairs and flags board clear.

---
 rtl/match_judge.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/match_judge.sv
// Pair-selection judge for the card array: waits for two selected cards, holds them on
// display, then pulses match/mismatch back to exactly the cards involved.
module match_judge #(
    parameter int N_CARDS     = 16,
    parameter int TYPE_W      = 3,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_CARDS-1:0]                sel,
    input  logic [N_CARDS*TYPE_W-1:0]         types,
    output logic [N_CARDS-1:0]                ms,
    output logic [N_CARDS-1:0]                mf,
    output logic                              busy,
    output logic [$clog2(N_CARDS/2+1)-1:0]    pairs_left,
    output logic                              all_clear
);
    localparam int IW = (N_CARDS > 1) ? $clog2(N_CARDS) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int PW = $clog2(N_CARDS/2+1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ONE   = 3'd1,
        HOLD  = 3'd2,
        JUDGE = 3'd3,
        WAIT  = 3'd4
    } state_t;

    state_t             state;
    logic [N_CARDS-1:0] pair_mask;
    logic [HW-1:0]      hold_cnt;
    logic [IW-1:0]      idx_a;
    logic [IW-1:0]      idx_b;

    // Lowest two set bits of sel; the found flags double as popcount 0 / 1 / >=2.
    logic               any_sel;
    logic               two_sel;
    logic [IW-1:0]      first_idx;
    logic [IW-1:0]      second_idx;
    logic [N_CARDS-1:0] new_mask;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        any_sel    = 1'b0;
        two_sel    = 1'b0;
        first_idx  = '0;
        second_idx = '0;
        for (int i = 0; i < N_CARDS; i++) begin
            if (sel[i]) begin
                if (!any_sel) begin
                    any_sel   = 1'b1;
                    first_idx = IW'(i);
                end else if (!two_sel) begin
                    two_sel    = 1'b1;
                    second_idx = IW'(i);
                end
            end
        end
        new_mask             = '0;
        new_mask[first_idx]  = 1'b1;
        new_mask[second_idx] = 1'b1;
    end

    logic [TYPE_W-1:0] type_a;
    logic [TYPE_W-1:0] type_b;
    logic              pair_intact;

    assign type_a      = types[idx_a*TYPE_W +: TYPE_W];
    assign type_b      = types[idx_b*TYPE_W +: TYPE_W];
    assign pair_intact = ((sel & pair_mask) == pair_mask);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pair_mask  <= '0;
            hold_cnt   <= '0;
            idx_a      <= '0;
            idx_b      <= '0;
            ms         <= '0;
            mf         <= '0;
            busy       <= 1'b0;
            pairs_left <= PW'(N_CARDS/2);
            all_clear  <= 1'b0;
        end else begin
            ms        <= '0;
            mf        <= '0;
            all_clear <= all_clear | (pairs_left == '0);

            case (state)
                IDLE, ONE: begin
                    if (two_sel) begin
                        pair_mask <= new_mask;
                        idx_a     <= first_idx;
                        idx_b     <= second_idx;
                        hold_cnt  <= '0;
                        busy      <= 1'b1;
                        state     <= HOLD;
                    end else if (any_sel) begin
                        state <= ONE;
                    end else begin
                        state <= IDLE;
                    end
                end

                HOLD: begin
                    if (!pair_intact) begin
                        pair_mask <= '0;
                        hold_cnt  <= '0;
                        busy      <= 1'b0;
                        state     <= (any_sel && !two_sel) ? ONE : IDLE;
                    end else if (hold_cnt == HW'(HOLD_CYCLES-1)) begin
                        state <= JUDGE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                JUDGE: begin
                    // Any stray selection beyond the pair is rejected alongside the verdict.
                    if (type_a == type_b) begin
                        ms <= pair_mask;
                        mf <= sel & ~pair_mask;
                        if (pairs_left != '0)
                            pairs_left <= pairs_left - 1'b1;
                    end else begin
                        mf <= pair_mask | (sel & ~pair_mask);
                    end
                    state <= WAIT;
                end

                WAIT: begin
                    // Cards drop sel a couple of edges after the pulse; wait for both.
                    if ((sel & pair_mask) == '0) begin
                        pair_mask <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    pair_mask <= '0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule
